// File: rtl/writeback_arbiter_if.sv
// Execute->writeback interface: X-pipe and M-pipe results in, register-file write port out.
// WB_BYPASS_EN adds the bypass lookup signals (is_wb_rdaddr, wb_is_hit, wb_is_data).
interface writeback_arbiter_if;
  logic [4:0]  x_wb_regdest;
  logic        x_wb_writereg;
  logic [31:0] x_wb_wbvalue;
  logic [4:0]  m_wb_regdest;
  logic        m_wb_writereg;
  logic [31:0] m_wb_wbvalue;
  logic        wb_rf_writeen;
  logic [4:0]  wb_rf_writeaddr;
  logic [31:0] wb_rf_writedata;
  logic        wb_is_stall;
  logic        wb_overflow;
`ifdef WB_BYPASS_EN
  logic [4:0]  is_wb_rdaddr;
  logic        wb_is_hit;
  logic [31:0] wb_is_data;
`endif

  // Pipeline side: produces results, observes the RF write port and back-pressure.
  modport master (
    output x_wb_regdest, output x_wb_writereg, output x_wb_wbvalue,
    output m_wb_regdest, output m_wb_writereg, output m_wb_wbvalue,
    input  wb_rf_writeen, input wb_rf_writeaddr, input wb_rf_writedata,
    input  wb_is_stall, input wb_overflow
`ifdef WB_BYPASS_EN
    , output is_wb_rdaddr, input wb_is_hit, input wb_is_data
`endif
  );

  // Arbiter side.
  modport slave (
    input  x_wb_regdest, input x_wb_writereg, input x_wb_wbvalue,
    input  m_wb_regdest, input m_wb_writereg, input m_wb_wbvalue,
    output wb_rf_writeen, output wb_rf_writeaddr, output wb_rf_writedata,
    output wb_is_stall, output wb_overflow
`ifdef WB_BYPASS_EN
    , input is_wb_rdaddr, output wb_is_hit, output wb_is_data
`endif
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: serialises X-pipe and M-pipe results onto one register-file write port,
// buffering collisions in an in-order FIFO. Optional bypass lookup under WB_BYPASS_EN.
module writeback_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic              clock,
  input  logic              reset,
  writeback_arbiter_if.slave wb
);
  localparam int unsigned PTR_W = CNT_W - 1;
  typedef logic [PTR_W-1:0] ptr_t;

  logic             x_v, m_v;
  logic [CNT_W-1:0] count_q, count_d;
  ptr_t             rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, wr_ptr_m;
  logic [4:0]       fifo_addr_q [FIFO_DEPTH];
  logic [4:0]       fifo_addr_d [FIFO_DEPTH];
  logic [31:0]      fifo_data_q [FIFO_DEPTH];
  logic [31:0]      fifo_data_d [FIFO_DEPTH];
  logic             en_q, en_d;
  logic [4:0]       addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             ovf_q, ovf_d;
  logic             pop, x_want, m_want, push_x, push_m;
  logic [CNT_W-1:0] avail;

  // Writes to r0 are architecturally discarded, so they never count as requests.
  assign x_v = wb.x_wb_writereg & (wb.x_wb_regdest != 5'd0);
  assign m_v = wb.m_wb_writereg & (wb.m_wb_regdest != 5'd0);

  // Commit selection (head > X > M), enqueue of uncommitted results, pointer/count update.
  always_comb begin
    pop    = 1'b0;
    x_want = 1'b0;
    m_want = 1'b0;
    en_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (count_q != '0) begin
      pop    = 1'b1;
      en_d   = 1'b1;
      addr_d = fifo_addr_q[rd_ptr_q];
      data_d = fifo_data_q[rd_ptr_q];
      x_want = x_v;
      m_want = m_v;
    end else if (x_v) begin
      en_d   = 1'b1;
      addr_d = wb.x_wb_regdest;
      data_d = wb.x_wb_wbvalue;
      m_want = m_v;
    end else if (m_v) begin
      en_d   = 1'b1;
      addr_d = wb.m_wb_regdest;
      data_d = wb.m_wb_wbvalue;
    end

    // The head popped this cycle frees its slot for a same-cycle push.
    avail  = CNT_W'(FIFO_DEPTH) - count_q + CNT_W'(pop);
    push_x = x_want && (avail != '0);
    push_m = m_want && (avail > CNT_W'(push_x));
    ovf_d  = ovf_q | (x_want & ~push_x) | (m_want & ~push_m);

    wr_ptr_m    = wr_ptr_q + ptr_t'(push_x);
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    if (push_x) begin
      fifo_addr_d[wr_ptr_q] = wb.x_wb_regdest;
      fifo_data_d[wr_ptr_q] = wb.x_wb_wbvalue;
    end
    if (push_m) begin
      fifo_addr_d[wr_ptr_m] = wb.m_wb_regdest;
      fifo_data_d[wr_ptr_m] = wb.m_wb_wbvalue;
    end

    wr_ptr_d = wr_ptr_q + ptr_t'(push_x) + ptr_t'(push_m);
    rd_ptr_d = rd_ptr_q + ptr_t'(pop);
    count_d  = count_q + CNT_W'(push_x) + CNT_W'(push_m) - CNT_W'(pop);
  end

  // State and output registers; reset discards everything pending.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      en_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
    end else begin
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      en_q        <= en_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      ovf_q       <= ovf_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
    end
  end

  assign wb.wb_rf_writeen   = en_q;
  assign wb.wb_rf_writeaddr = addr_q;
  assign wb.wb_rf_writedata = data_q;
  assign wb.wb_overflow     = ovf_q;
  // Two free slots guarantee both pipes can push next cycle without a drop.
  assign wb.wb_is_stall     = (count_q >= CNT_W'(FIFO_DEPTH - 2));

`ifdef WB_BYPASS_EN
  logic        byp_hit;
  logic [31:0] byp_data;
  ptr_t        byp_idx;

  // Youngest-match lookup: later checks override earlier ones, so scan oldest to youngest.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    byp_idx  = rd_ptr_q;
    if (wb.is_wb_rdaddr != 5'd0) begin
      if (en_q && (addr_q == wb.is_wb_rdaddr)) begin
        byp_hit  = 1'b1;
        byp_data = data_q;
      end
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        byp_idx = rd_ptr_q + ptr_t'(i);
        if ((CNT_W'(i) < count_q) && (fifo_addr_q[byp_idx] == wb.is_wb_rdaddr)) begin
          byp_hit  = 1'b1;
          byp_data = fifo_data_q[byp_idx];
        end
      end
      if (x_v && (wb.x_wb_regdest == wb.is_wb_rdaddr)) begin
        byp_hit  = 1'b1;
        byp_data = wb.x_wb_wbvalue;
      end
      if (m_v && (wb.m_wb_regdest == wb.is_wb_rdaddr)) begin
        byp_hit  = 1'b1;
        byp_data = wb.m_wb_wbvalue;
      end
    end
  end

  assign wb.wb_is_hit  = byp_hit;
  assign wb.wb_is_data = byp_data;
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter; bypass checks compile in with WB_BYPASS_EN.
module tb_writeback_arbiter;
  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;

  writeback_arbiter_if bus ();

  writeback_arbiter #(
    .FIFO_DEPTH (4),
    .CNT_W      (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .wb    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_x(input logic [4:0] rd, input logic [31:0] val);
    bus.x_wb_regdest  = rd;
    bus.x_wb_writereg = 1'b1;
    bus.x_wb_wbvalue  = val;
  endtask

  task automatic drive_m(input logic [4:0] rd, input logic [31:0] val);
    bus.m_wb_regdest  = rd;
    bus.m_wb_writereg = 1'b1;
    bus.m_wb_wbvalue  = val;
  endtask

  task automatic idle();
    bus.x_wb_regdest  = '0;
    bus.x_wb_writereg = 1'b0;
    bus.x_wb_wbvalue  = '0;
    bus.m_wb_regdest  = '0;
    bus.m_wb_writereg = 1'b0;
    bus.m_wb_wbvalue  = '0;
  endtask

  task automatic check_wr(input string tag, input logic en, input logic [4:0] a,
                          input logic [31:0] d);
    check_eq({tag, "_en"}, 32'(bus.wb_rf_writeen), 32'(en));
    check_eq({tag, "_addr"}, 32'(bus.wb_rf_writeaddr), 32'(a));
    check_eq({tag, "_data"}, bus.wb_rf_writedata, d);
  endtask

  logic [31:0] exp_data [5];
  logic        exp_stall [5];
  logic        exp_ovf [5];

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();
`ifdef WB_BYPASS_EN
    bus.is_wb_rdaddr = '0;
`endif
    reset = 1'b1;
    tick();
    tick();
    check_wr("rst", 1'b0, 5'd0, 32'h0);
    check_eq("rst_stall", 32'(bus.wb_is_stall), 32'd0);
    check_eq("rst_ovf", 32'(bus.wb_overflow), 32'd0);
    reset = 1'b0;

    // Single X write, latency 1, then hold.
    drive_x(5'd5, 32'h11);
    tick();
    idle();
    check_wr("t1", 1'b1, 5'd5, 32'h11);
    check_eq("t1_stall", 32'(bus.wb_is_stall), 32'd0);
    tick();
    check_wr("t1_hold", 1'b0, 5'd5, 32'h11);

    // X and M together: X first, M one cycle later.
    drive_x(5'd3, 32'hA);
    drive_m(5'd4, 32'hB);
    tick();
    idle();
    check_wr("t2_x", 1'b1, 5'd3, 32'hA);
    check_eq("t2_stall", 32'(bus.wb_is_stall), 32'd0);
    tick();
    check_wr("t2_m", 1'b1, 5'd4, 32'hB);
    tick();
    check_eq("t2_idle", 32'(bus.wb_rf_writeen), 32'd0);

    // Same-register ordering: 1, then same-cycle X(3) before M(2).
    drive_x(5'd7, 32'h1);
    tick();
    drive_x(5'd7, 32'h3);
    drive_m(5'd7, 32'h2);
    check_wr("t3_a", 1'b1, 5'd7, 32'h1);
    tick();
    idle();
    check_wr("t3_b", 1'b1, 5'd7, 32'h3);
    tick();
    check_wr("t3_c", 1'b1, 5'd7, 32'h2);
    tick();

    // r0 write is dropped; FIFO stays empty so the next write has latency 1.
    drive_x(5'd0, 32'hDEAD);
    tick();
    idle();
    check_eq("t5_en", 32'(bus.wb_rf_writeen), 32'd0);
    drive_x(5'd1, 32'h77);
    tick();
    idle();
    check_wr("t5_next", 1'b1, 5'd1, 32'h77);
    tick();

    // Saturate both pipes: X r10=0x100+k, M r11=0x200+k.
    exp_data  = '{32'h100, 32'h200, 32'h101, 32'h201, 32'h102};
    exp_stall = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_ovf   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      drive_x(5'd10, 32'h100 + 32'(k));
      drive_m(5'd11, 32'h200 + 32'(k));
      tick();
      check_eq($sformatf("t4_data%0d", k), bus.wb_rf_writedata, exp_data[k]);
      check_eq($sformatf("t4_stall%0d", k), 32'(bus.wb_is_stall), 32'(exp_stall[k]));
      check_eq($sformatf("t4_ovf%0d", k), 32'(bus.wb_overflow), 32'(exp_ovf[k]));
    end
    idle();
`ifdef WB_BYPASS_EN
    // FIFO holds M2(r11) X3(r10) M3(r11) X4(r10).
    bus.is_wb_rdaddr = 5'd11;
    #1;
    check_eq("byp_r11_hit", 32'(bus.wb_is_hit), 32'd1);
    check_eq("byp_r11_data", bus.wb_is_data, 32'h203);
    bus.is_wb_rdaddr = 5'd10;
    #1;
    check_eq("byp_r10_data", bus.wb_is_data, 32'h104);
    bus.is_wb_rdaddr = 5'd0;
`endif
    tick();
    check_wr("t4_m2", 1'b1, 5'd11, 32'h202);

    // Three entries pending; asynchronous reset mid-cycle.
    #3;
    reset = 1'b1;
    #1;
    check_wr("t6_async", 1'b0, 5'd0, 32'h0);
    check_eq("t6_ovf", 32'(bus.wb_overflow), 32'd0);
    check_eq("t6_stall", 32'(bus.wb_is_stall), 32'd0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq($sformatf("t6_quiet%0d", k), 32'(bus.wb_rf_writeen), 32'd0);
    end

`ifdef WB_BYPASS_EN
    // r8 in the output register, r9 pending in the FIFO.
    drive_x(5'd8, 32'h1);
    drive_m(5'd9, 32'h55);
    tick();
    idle();
    bus.is_wb_rdaddr = 5'd9;
    #1;
    check_eq("byp_r9_hit", 32'(bus.wb_is_hit), 32'd1);
    check_eq("byp_r9_data", bus.wb_is_data, 32'h55);
    bus.is_wb_rdaddr = 5'd8;
    #1;
    check_eq("byp_r8_data", bus.wb_is_data, 32'h1);
    bus.is_wb_rdaddr = 5'd12;
    #1;
    check_eq("byp_miss_hit", 32'(bus.wb_is_hit), 32'd0);
    check_eq("byp_miss_data", bus.wb_is_data, 32'h0);
    bus.is_wb_rdaddr = 5'd0;
    #1;
    check_eq("byp_r0_hit", 32'(bus.wb_is_hit), 32'd0);
    bus.is_wb_rdaddr = 5'd9;
    drive_m(5'd9, 32'h66);
    #1;
    check_eq("byp_min_data", bus.wb_is_data, 32'h66);
    idle();
    bus.is_wb_rdaddr = 5'd0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
